imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the byte-addressed instruction memory of the single-cycle CPU. It accepts a stream of program bytes over a valid/ready handshake and issues sequential byte writes into the 256-byte instruction store. Bytes are written in the big-endian order the fetch path reads them: the byte at pc is instruction[31:24]. While a load is in progress it holds the CPU so that no fetch observes a partially written program.

## Interface
- `ADDR_W`, default 8: byte address width. Memory depth is 2^ADDR_W bytes.
- `clk` input 1: sole clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a load. Sampled only in IDLE.
- `base_addr` input ADDR_W: first byte address. Latched on an accepted `start`.
- `byte_cnt` input ADDR_W+1: number of bytes to load. Legal range is 1..2^ADDR_W. Latched on `start`.
- `in_valid` input 1: `in_data` is valid.
- `in_data` input 8: program byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `abort` input 1: cancels a load in progress.
- `mem_we` output 1: byte write strobe to the instruction memory.
- `mem_addr` output ADDR_W: write address.
- `mem_wdata` output 8: write data.
- `busy` output 1: asserted whenever state is not IDLE.
- `cpu_hold` output 1: equal to `busy`. The PC/fetch stage stalls while it is high.
- `done` output 1: one-cycle pulse when a load completes.
- `err` output 1: one-cycle pulse when `start` is rejected.
- `checksum` output 8: sum mod 256 of the bytes accepted in the current or last load.

## Operation
- States are IDLE, LOAD and FINISH.
- **IDLE:**
  - `in_ready`=0.
  - `start`=1 with `byte_cnt` in 1..2^ADDR_W: latch `base_addr` into the address pointer, set remaining=`byte_cnt`, clear `checksum`, then go to LOAD.
  - `start`=1 with `byte_cnt`=0 or `byte_cnt` > 2^ADDR_W: pulse `err` next cycle and stay in IDLE. `checksum` is unchanged.
- **LOAD:**
  - `in_ready` = (state==LOAD) && !`abort`. This is combinational from state.
  - A handshake is `in_valid` && `in_ready`. On a handshake:
    - capture the byte into the write register;
    - `checksum` += byte, mod 256;
    - pointer += 1, wrapping mod 2^ADDR_W;
    - remaining -= 1.
  - A handshake with remaining==1 (the last byte) goes to FINISH.
  - `start` is ignored in LOAD.
  - `abort`=1 goes to IDLE with no `done`. Bytes already written stay written.
- **FINISH:**
  - Lasts exactly one cycle. `in_ready`=0 and `done`=1.
  - The write for the last byte is issued in this cycle.
  - Returns to IDLE.
- **Write port:**
  - `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - A byte accepted in cycle N produces `mem_we`=1 in cycle N+1, with `mem_addr` = the pointer value at acceptance and `mem_wdata` = the byte.
  - With no handshake in cycle N, `mem_we`=0 in cycle N+1. Address and data hold their last values.
- **Abort:** a write registered before the abort cycle still issues in that cycle.
- **Address wrap:** FF + 1 wraps to 00. A load of length 2^ADDR_W covers every address exactly once.

## Timing
- **Reset:** on `rst_n`=0, asynchronously:
  - state goes to IDLE;
  - `in_ready`, `mem_we`, `busy`, `cpu_hold`, `done` and `err` all go to 0;
  - `mem_addr`, `mem_wdata` and `checksum` go to 0.
- **Reset mid-load:** the load is lost. A write registered in the same cycle is dropped.
- **Latency:**
  - `start` to LOAD (`in_ready` may assert) is 1 cycle.
  - Byte accept to memory write is 1 cycle.
  - Last byte accept to `done` is 1 cycle; `done` coincides with the last write.
  - `busy` falls 2 cycles after the last accept.
- **Throughput:** with `in_valid` held high, the loader accepts one byte per cycle with no bubbles.
- **Source rules:** the source may deassert `in_valid` at any time. A byte is consumed only on a handshake.
- **Simultaneous events:**
  - `abort` and `in_valid` in the same cycle: no accept.
  - `start` and `abort` in IDLE: the `start` is honoured and `abort` is ignored.
- `checksum` is stable from `done` until the next accepted `start`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → every output is 0 immediately. After release, state is IDLE and `in_ready`=0.
- **Basic load:**
  - Stimulus: `base_addr`=00, `byte_cnt`=4, bytes 20,01,00,05 with back-to-back valid.
  - Required writes: (00,20), (01,01), (02,00), (03,05) on consecutive cycles.
  - Required status: `done` coincides with the write to 03, `checksum`=26, `busy` is high for 6 cycles.
- **Backpressure / gaps:** same 4 bytes with `in_valid` deasserted 2 cycles between bytes → identical writes. `mem_we` is high only 1 cycle after each accept and `cpu_hold` stays high throughout.
- **Wrap:** `base_addr`=FE, `byte_cnt`=4, bytes AA,BB,CC,DD → writes to FE, FF, 00, 01. `checksum`=0E.
- **Rejected start:** `byte_cnt`=0, then `byte_cnt`=257 → `err` pulses each time. `busy` is never set, no writes occur, `checksum` is unchanged.
- **Abort:**
  - Stimulus: `byte_cnt`=8; accept 3 bytes, then `abort` together with `in_valid`=1.
  - Required: the 3rd write issues in the abort cycle, the 4th byte is not accepted, no `done` pulse, state returns to IDLE.
  - A following start then loads normally.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Streams program bytes into the byte-addressed instruction memory.
// Each byte accepted on the valid/ready handshake becomes one sequential
// byte write. The CPU is held for as long as a load is in progress.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle load request, sampled only in IDLE
//   base_addr  : first byte address, latched on an accepted start
//   byte_cnt   : number of bytes to load, legal 1..2^ADDR_W
//   in_valid   : in_data carries a program byte
//   in_data    : program byte
//   in_ready   : loader takes a byte this cycle
//   abort      : cancels a load in progress
//   mem_we     : registered byte write strobe
//   mem_addr   : registered write address
//   mem_wdata  : registered write data
//   busy       : loader is not IDLE
//   cpu_hold   : fetch stall, identical to busy
//   done       : one-cycle pulse when a load completes
//   err        : one-cycle pulse after a rejected start
//   checksum   : sum mod 256 of bytes accepted in the current/last load
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   byte_cnt,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  // Largest legal byte count: the whole memory.
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] ptr_q,      ptr_d;
  logic [ADDR_W:0]   rem_q,      rem_d;
  logic [7:0]        sum_q,      sum_d;
  logic              we_q,       we_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [7:0]        wdata_q,    wdata_d;
  logic              err_q,      err_d;

  logic handshake;

  // Ready depends only on state and abort so a source can never see a
  // byte taken in the same cycle the load is cancelled.
  assign in_ready  = (state_q == S_LOAD) && !abort;
  assign handshake = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort is deliberately not looked at here: a start always wins.
        if (start) begin
          if ((byte_cnt != '0) && (byte_cnt <= MAX_CNT)) begin
            state_d = S_LOAD;
            ptr_d   = base_addr;
            rem_d   = byte_cnt;
            sum_d   = 8'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (handshake) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_data;
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          sum_d   = sum_q + in_data;
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = S_FINISH;
          end
        end
      end

      // The last write is on the port during this single cycle.
      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign cpu_hold  = busy;
  assign done      = (state_q == S_FINISH);
  assign err       = err_q;
  assign checksum  = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed stimulus for imem_loader. A byte-stream model predicts every
// output each cycle; literal expectations pin the write sequences,
// checksums and pulse counts of each scenario.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic [8:0] byte_cnt = 9'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       abort = 1'b0;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       cpu_hold;
  logic       done;
  logic       err;
  logic [7:0] checksum;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .byte_cnt(byte_cnt), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // A load is "bytes still owed" plus a one-cycle completion marker.
  logic       m_loading, m_finish, m_we, m_err;
  int         m_left;
  logic [7:0] m_ptr, m_sum, m_addr, m_wdata;
  logic       acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading <= 1'b0; m_finish <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
      m_left <= 0; m_ptr <= 8'd0; m_sum <= 8'd0; m_addr <= 8'd0; m_wdata <= 8'd0;
    end else begin
      acc = m_loading && !abort && in_valid;
      m_we     <= acc;
      m_err    <= 1'b0;
      m_finish <= 1'b0;
      if (acc) begin
        m_addr  <= m_ptr;
        m_wdata <= in_data;
        m_ptr   <= m_ptr + 8'd1;
        m_sum   <= m_sum + in_data;
        m_left  <= m_left - 1;
      end
      if (!m_loading && !m_finish) begin
        if (start) begin
          if (byte_cnt >= 9'd1 && byte_cnt <= 9'd256) begin
            m_loading <= 1'b1;
            m_ptr     <= base_addr;
            m_left    <= int'(byte_cnt);
            m_sum     <= 8'd0;
          end else begin
            m_err <= 1'b1;
          end
        end
      end else if (m_loading && abort) begin
        m_loading <= 1'b0;
      end else if (acc && m_left == 1) begin
        m_loading <= 1'b0;
        m_finish  <= 1'b1;
      end
    end
  end

  // ---------------- compare + monitors ----------------
  logic [15:0] wlog[$];
  int busy_cnt, err_cnt, done_cnt, we_cnt;
  logic [7:0] done_addr;
  logic       done_we;

  always @(negedge clk) begin
    chk("in_ready",  32'(in_ready),  32'(m_loading && !abort));
    chk("mem_we",    32'(mem_we),    32'(m_we));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("busy",      32'(busy),      32'(m_loading || m_finish));
    chk("cpu_hold",  32'(cpu_hold),  32'(m_loading || m_finish));
    chk("done",      32'(done),      32'(m_finish));
    chk("err",       32'(err),       32'(m_err));
    chk("checksum",  32'(checksum),  32'(m_sum));
    if (busy) busy_cnt++;
    if (err) err_cnt++;
    if (mem_we) begin
      we_cnt++;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (done) begin
      done_cnt++;
      done_addr = mem_addr;
      done_we   = mem_we;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wlog.delete();
    busy_cnt = 0; err_cnt = 0; done_cnt = 0; we_cnt = 0;
    done_addr = 8'd0; done_we = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] c);
    start = 1'b1; base_addr = b; byte_cnt = c;
    step();
    start = 1'b0;
  endtask

  // Present one byte until it is taken, then idle for gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic check_log(input string name, input int n,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e[4];
    e = '{e0, e1, e2, e3};
    chk({name, "_nwrites"}, 32'(wlog.size()), 32'(n));
    for (int i = 0; i < n && i < wlog.size(); i++)
      chk($sformatf("%s_write%0d", name, i), 32'(wlog[i]), 32'(e[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    repeat (2) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic load; source raises valid one cycle after ready appears.
    clear_mon();
    do_start(8'h00, 9'd4);
    step();
    send(8'h20, 0); send(8'h01, 0); send(8'h00, 0); send(8'h05, 0);
    repeat (3) step();
    check_log("basic", 4, 16'h0020, 16'h0101, 16'h0200, 16'h0305);
    chk("basic_done_cnt",  32'(done_cnt),  32'd1);
    chk("basic_done_we",   32'(done_we),   32'd1);
    chk("basic_done_addr", 32'(done_addr), 32'h03);
    chk("basic_checksum",  32'(checksum),  32'h26);
    chk("basic_busy_cyc",  32'(busy_cnt),  32'd6);

    // Same bytes with two idle cycles between them.
    clear_mon();
    do_start(8'h00, 9'd4);
    send(8'h20, 2); send(8'h01, 2); send(8'h00, 2); send(8'h05, 0);
    repeat (3) step();
    check_log("gap", 4, 16'h0020, 16'h0101, 16'h0200, 16'h0305);
    chk("gap_we_cnt",   32'(we_cnt),   32'd4);
    chk("gap_busy_cyc", 32'(busy_cnt), 32'd11);
    chk("gap_checksum", 32'(checksum), 32'h26);

    // Address wrap.
    clear_mon();
    do_start(8'hFE, 9'd4);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    repeat (3) step();
    check_log("wrap", 4, 16'hFEAA, 16'hFFBB, 16'h00CC, 16'h01DD);
    chk("wrap_checksum", 32'(checksum), 32'h0E);
    chk("wrap_done_cnt", 32'(done_cnt), 32'd1);

    // Rejected starts.
    clear_mon();
    do_start(8'h33, 9'd0);
    step();
    do_start(8'h33, 9'd257);
    repeat (3) step();
    chk("rej_err_cnt",  32'(err_cnt),     32'd2);
    chk("rej_busy_cyc", 32'(busy_cnt),    32'd0);
    chk("rej_nwrites",  32'(wlog.size()), 32'd0);
    chk("rej_checksum", 32'(checksum),    32'h0E);

    // Abort after three bytes, with a fourth byte offered.
    clear_mon();
    do_start(8'h10, 9'd8);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h04;
    #1;
    chk("abort_in_ready", 32'(in_ready),  32'd0);
    chk("abort_we",       32'(mem_we),    32'd1);
    chk("abort_addr",     32'(mem_addr),  32'h12);
    chk("abort_wdata",    32'(mem_wdata), 32'h03);
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    repeat (3) step();
    check_log("abort", 3, 16'h1001, 16'h1102, 16'h1203, 16'h0000);
    chk("abort_done_cnt", 32'(done_cnt), 32'd0);
    chk("abort_checksum", 32'(checksum), 32'h06);

    clear_mon();
    do_start(8'h40, 9'd2);
    send(8'h11, 0); send(8'h22, 0);
    repeat (3) step();
    check_log("post_abort", 2, 16'h4011, 16'h4122, 16'h0000, 16'h0000);
    chk("post_abort_checksum", 32'(checksum), 32'h33);
    chk("post_abort_done_cnt", 32'(done_cnt), 32'd1);

    // Reset in the middle of a load while a write is pending.
    clear_mon();
    do_start(8'h80, 9'd4);
    send(8'h5A, 0);
    in_valid = 1'b1; in_data = 8'h5B;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready",  32'(in_ready),  32'd0);
    chk("mrst_mem_we",    32'(mem_we),    32'd0);
    chk("mrst_mem_addr",  32'(mem_addr),  32'd0);
    chk("mrst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("mrst_busy",      32'(busy),      32'd0);
    chk("mrst_cpu_hold",  32'(cpu_hold),  32'd0);
    chk("mrst_done",      32'(done),      32'd0);
    chk("mrst_err",       32'(err),       32'd0);
    chk("mrst_checksum",  32'(checksum),  32'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd0);
    chk("post_rst_busy",     32'(busy),     32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
